stack_cmd_decoder: RTL and testbench
====================================

# stack_cmd_decoder

Upstream command front-end for the stack calculator: accepts one 4-bit nibble per clock from the input pins, assembles opcodes and their immediate operands, and issues one registered stack command (mode + word) per cycle to `stack_register`. Tracks stack occupancy to suppress and flag underflow/overflow before the command reaches the stack. Sits between the pin-level input nibble and the stack register inside `stack_cpu`.

## Interface
Parameters:
- `DEPTH`, 8: number of words the downstream stack holds; overflow limit.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: nibble on `in_nibble` is consumed this edge.
- `in_nibble` in 4: opcode or operand nibble.
- `mode` out 3: stack command to `stack_register`.
- `in_word` out 4: data word for push commands; 0 otherwise.
- `cmd_valid` out 1: one-cycle pulse, `mode`/`in_word` are a real command.
- `busy` out 1: high while waiting for operand nibbles.
- `depth` out $clog2(DEPTH+1): current stack occupancy.
- `err_pulse` out 1: one-cycle error strobe.
- `err_code` out 2: 01 illegal opcode, 10 underflow, 11 overflow; held until next error.
- `err_flag` out 1: sticky error, cleared only by reset.

## Operation
- Mode encoding: 000 POP, 001 PUSH, 010 ADD, 011 SUB, 100 SWAP, 101 DUP, 110 NOP, 111 reserved (never driven).
- Opcodes (IDLE nibble): 0 NOP, 1 PUSH (1 operand), 2 POP, 3 ADD, 4 SUB, 5 SWAP, 6 DUP, 7 PUSH2 (2 operands, two pushes); 8–F illegal.
- FSM states: IDLE, OPND1, OPND2. All transitions only on `in_valid`=1; `in_valid`=0 holds state indefinitely (no timeout).
  - IDLE + opcode 1 or 7 -> OPND1 (7 remembered). Other legal opcodes issue their command, stay IDLE. Opcode 0 issues nothing (`cmd_valid`=0). Illegal -> error 01, stay IDLE.
  - OPND1: issue PUSH with nibble; -> IDLE for PUSH, -> OPND2 for PUSH2.
  - OPND2: issue PUSH with nibble; -> IDLE.
- Depth requirements / effect: PUSH needs depth<DEPTH, +1; POP needs ≥1, −1; ADD/SUB need ≥2, −1; SWAP needs ≥2, 0; DUP needs ≥1 and <DEPTH, +1.
- Violated requirement: command suppressed (`cmd_valid`=0, `mode`=NOP), depth unchanged, error 10 (under) or 11 (over); DUP at full is overflow, DUP at empty underflow.
- Overflow in OPND1 of PUSH2: operand consumed, first push suppressed, FSM still goes to OPND2 (second operand still consumed and checked). Overflow in OPND2 suppresses only the second push.
- Depth counter saturates by construction; never wraps.

## Timing
- Reset values: `mode`=110, `in_word`=0, `cmd_valid`=0, `busy`=0, `depth`=0, `err_pulse`=0, `err_code`=00, `err_flag`=0, FSM=IDLE.
- All outputs registered. Command appears the cycle after the edge that consumed the final nibble (latency 1); `depth` updates on the same edge.
- `busy` registered: high the cycle after entering OPND1/OPND2, low the cycle after return to IDLE.
- Between commands `mode` returns to 110, `in_word` to 0.
- Reset asserted mid-operand: FSM to IDLE, partial command discarded, depth 0; no command emitted on deassertion.
- Back-to-back: one nibble per clock sustained, one command per clock max.

## Configuration
- `STACK_DEPTH_CHECK_EN` defined: depth tracking, suppression and error codes 10/11 as above.
- Not defined: no counter; `depth` tied 0; every legal command issues unconditionally; only error 01 possible.

## Structure
- Shared package `stack_pkg`: mode encoding constants, opcode constants, error code constants, FSM state typedef.
- One sub-module: `stack_depth_tracker` (depth counter + legality check), instantiated only under `STACK_DEPTH_CHECK_EN`.

## Test plan
- Reset, nibbles 1,5 -> next cycle `mode`=001, `in_word`=5, `cmd_valid`=1, `depth`=1; `busy` high one cycle between.
- Empty stack, nibble 3 (ADD) -> `cmd_valid`=0, `err_pulse`=1, `err_code`=10, `err_flag` sticky, `depth`=0.
- Push DEPTH=8 words via PUSH2 ×4, then 1,A -> ninth push suppressed, `err_code`=11, `depth`=8.
- Nibble 1, `in_valid` low 5 cycles, then A, reset asserted before A's edge -> no command, FSM IDLE, `depth`=0.
- Nibble C -> `err_code`=01, FSM stays IDLE; following 2 with depth 1 -> POP issued, `depth`=0.
- Macro undefined: nibble 3 on empty stack -> `mode`=010, `cmd_valid`=1, no error.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack calculator front-end: stack command
// encodings, input opcodes, error codes and the decoder FSM state type.
package stack_pkg;

  localparam logic [2:0] MODE_POP  = 3'b000;
  localparam logic [2:0] MODE_PUSH = 3'b001;
  localparam logic [2:0] MODE_ADD  = 3'b010;
  localparam logic [2:0] MODE_SUB  = 3'b011;
  localparam logic [2:0] MODE_SWAP = 3'b100;
  localparam logic [2:0] MODE_DUP  = 3'b101;
  localparam logic [2:0] MODE_NOP  = 3'b110;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSH  = 4'h1;
  localparam logic [3:0] OP_POP   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_SWAP  = 4'h5;
  localparam logic [3:0] OP_DUP   = 4'h6;
  localparam logic [3:0] OP_PUSH2 = 4'h7;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_UNDER   = 2'b10;
  localparam logic [1:0] ERR_OVER    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPND1 = 2'd1,
    ST_OPND2 = 2'd2
  } state_t;

  // Maps a single-nibble (operand-free) opcode to its stack command.
  function automatic logic [2:0] opcodeToMode(input logic [3:0] op);
    logic [2:0] m;
    case (op)
      OP_POP:  m = MODE_POP;
      OP_ADD:  m = MODE_ADD;
      OP_SUB:  m = MODE_SUB;
      OP_SWAP: m = MODE_SWAP;
      OP_DUP:  m = MODE_DUP;
      default: m = MODE_NOP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/stack_cmd_decoder_if.sv
// Nibble input and stack-command output bundle of the command decoder.
// master: the side supplying nibbles; slave: the decoder itself.
interface stack_cmd_decoder_if #(
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic [3:0]    in_nibble;
  logic [2:0]    mode;
  logic [3:0]    in_word;
  logic          cmd_valid;
  logic          busy;
  logic [DW-1:0] depth;
  logic          err_pulse;
  logic [1:0]    err_code;
  logic          err_flag;

  modport master (
    output in_valid, in_nibble,
    input  mode, in_word, cmd_valid, busy, depth, err_pulse, err_code, err_flag
  );

  modport slave (
    input  in_valid, in_nibble,
    output mode, in_word, cmd_valid, busy, depth, err_pulse, err_code, err_flag
  );

endinterface

// File: rtl/stack_depth_tracker.sv
// Occupancy counter for the downstream stack. Judges whether a requested
// command fits the current depth and moves the count only when it does,
// so the count can never leave 0..DEPTH.
module stack_depth_tracker
  import stack_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [2:0]    i_mode,
  output logic          o_allow,
  output logic          o_under,
  output logic [DW-1:0] o_depth
);

  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [DW-1:0] r_depth;
  logic          w_under;
  logic          w_over;
  logic          w_inc;
  logic          w_dec;

  // Minimum-occupancy / free-slot requirement and depth effect per command.
  always_comb begin
    w_under = 1'b0;
    w_over  = 1'b0;
    w_inc   = 1'b0;
    w_dec   = 1'b0;
    case (i_mode)
      MODE_PUSH: begin
        w_over = (r_depth == FULL);
        w_inc  = 1'b1;
      end
      MODE_POP: begin
        w_under = (r_depth == '0);
        w_dec   = 1'b1;
      end
      MODE_ADD, MODE_SUB: begin
        w_under = (r_depth < DW'(2));
        w_dec   = 1'b1;
      end
      MODE_SWAP: begin
        w_under = (r_depth < DW'(2));
      end
      MODE_DUP: begin
        w_under = (r_depth == '0);
        w_over  = (r_depth == FULL);
        w_inc   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_allow = !w_under && !w_over;
  assign o_under = w_under;
  assign o_depth = r_depth;

  // Occupancy moves only for commands that actually reach the stack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_depth <= '0;
    end else if (i_req && o_allow) begin
      if (w_inc) begin
        r_depth <= r_depth + DW'(1);
      end else if (w_dec) begin
        r_depth <= r_depth - DW'(1);
      end
    end
  end

endmodule

// File: rtl/stack_cmd_decoder.sv
// Nibble-serial command front-end for the stack calculator. Assembles
// opcodes and immediate operands and issues one registered stack command
// per cycle. Build option STACK_DEPTH_CHECK_EN adds occupancy tracking that
// suppresses and flags underflow/overflow; without it every legal command
// is issued and depth reads 0.
module stack_cmd_decoder
  import stack_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  stack_cmd_decoder_if.slave bus
);

  localparam int DW = $clog2(DEPTH + 1);

  state_t        r_state;
  state_t        w_stateNext;
  logic          r_push2;
  logic          w_push2Next;

  logic          w_req;
  logic [2:0]    w_mode;
  logic [3:0]    w_word;
  logic          w_illegal;

  logic          w_allow;
  logic          w_under;
  logic [DW-1:0] w_depth;

  logic [2:0]    r_mode;
  logic [3:0]    r_word;
  logic          r_cmdValid;
  logic          r_busy;
  logic          r_errPulse;
  logic [1:0]    r_errCode;
  logic          r_errFlag;

  // State register; r_push2 remembers that the pending operand run is PUSH2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_push2 <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_push2 <= w_push2Next;
    end
  end

  // Next state and the command request decoded from the consumed nibble.
  always_comb begin
    w_stateNext = r_state;
    w_push2Next = r_push2;
    w_req       = 1'b0;
    w_mode      = MODE_NOP;
    w_word      = 4'h0;
    w_illegal   = 1'b0;
    if (bus.in_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_nibble == OP_PUSH) begin
            w_stateNext = ST_OPND1;
            w_push2Next = 1'b0;
          end else if (bus.in_nibble == OP_PUSH2) begin
            w_stateNext = ST_OPND1;
            w_push2Next = 1'b1;
          end else if (bus.in_nibble == OP_NOP) begin
            w_req = 1'b0;
          end else if (bus.in_nibble[3]) begin
            w_illegal = 1'b1;
          end else begin
            w_req  = 1'b1;
            w_mode = opcodeToMode(bus.in_nibble);
          end
        end
        ST_OPND1: begin
          w_req       = 1'b1;
          w_mode      = MODE_PUSH;
          w_word      = bus.in_nibble;
          w_stateNext = r_push2 ? ST_OPND2 : ST_IDLE;
        end
        ST_OPND2: begin
          w_req       = 1'b1;
          w_mode      = MODE_PUSH;
          w_word      = bus.in_nibble;
          w_stateNext = ST_IDLE;
        end
        default: begin
          w_stateNext = ST_IDLE;
        end
      endcase
    end
  end

`ifdef STACK_DEPTH_CHECK_EN
  stack_depth_tracker #(
    .DEPTH (DEPTH)
  ) u_depthTracker (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_req),
    .i_mode  (w_mode),
    .o_allow (w_allow),
    .o_under (w_under),
    .o_depth (w_depth)
  );
`else
  assign w_allow = 1'b1;
  assign w_under = 1'b0;
  assign w_depth = '0;
`endif

  // Output register: command or NOP idle value, busy, and error reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode     <= MODE_NOP;
      r_word     <= 4'h0;
      r_cmdValid <= 1'b0;
      r_busy     <= 1'b0;
      r_errPulse <= 1'b0;
      r_errCode  <= ERR_NONE;
      r_errFlag  <= 1'b0;
    end else begin
      r_busy     <= (w_stateNext != ST_IDLE);
      r_errPulse <= 1'b0;
      if (w_req && w_allow) begin
        r_mode     <= w_mode;
        r_word     <= w_word;
        r_cmdValid <= 1'b1;
      end else begin
        r_mode     <= MODE_NOP;
        r_word     <= 4'h0;
        r_cmdValid <= 1'b0;
      end
      if (w_illegal) begin
        r_errPulse <= 1'b1;
        r_errCode  <= ERR_ILLEGAL;
        r_errFlag  <= 1'b1;
      end else if (w_req && !w_allow) begin
        r_errPulse <= 1'b1;
        r_errCode  <= w_under ? ERR_UNDER : ERR_OVER;
        r_errFlag  <= 1'b1;
      end
    end
  end

  assign bus.mode      = r_mode;
  assign bus.in_word   = r_word;
  assign bus.cmd_valid = r_cmdValid;
  assign bus.busy      = r_busy;
  assign bus.depth     = w_depth;
  assign bus.err_pulse = r_errPulse;
  assign bus.err_code  = r_errCode;
  assign bus.err_flag  = r_errFlag;

endmodule

// File: tb/tb_stack_cmd_decoder.sv
// Testbench for stack_cmd_decoder: a directed vector table, hand-written
// overflow and mid-operand reset sequences, and randomized nibble streams
// checked against a behavioural model. Follows STACK_DEPTH_CHECK_EN.
module tb_stack_cmd_decoder;

  localparam int DEPTH = 8;
`ifdef STACK_DEPTH_CHECK_EN
  localparam bit DCHK = 1'b1;
`else
  localparam bit DCHK = 1'b0;
`endif

  typedef struct {
    logic       v;
    logic [3:0] n;
    logic [2:0] mode;
    logic [3:0] word;
    logic       cmd;
    logic       errP;
    logic [1:0] code;
    logic       flag;
    logic [3:0] depth;
    logic       busy;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stack_cmd_decoder_if #(.DEPTH(DEPTH)) busIf ();

  stack_cmd_decoder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Behavioural model state: occupancy and the nibbles of the instruction in progress.
  int         occ;
  logic [3:0] pend[$];
  logic [2:0] expMode;
  logic [3:0] expWord;
  logic       expCmd;
  logic       expBusy;
  logic       expErrPulse;
  logic [1:0] expErrCode;
  logic       expErrFlag;
  logic [3:0] expDepth;

  function automatic logic [3:0] dv(input int x);
    return DCHK ? 4'(x) : 4'd0;
  endfunction

  function automatic vec_t mk(input logic v, input logic [3:0] n, input logic [2:0] m,
                              input logic [3:0] w, input logic c, input logic ep,
                              input logic [1:0] ec, input logic ef, input logic [3:0] d,
                              input logic b);
    vec_t r;
    r.v = v; r.n = n; r.mode = m; r.word = w; r.cmd = c;
    r.errP = ep; r.code = ec; r.flag = ef; r.depth = d; r.busy = b;
    return r;
  endfunction

  task automatic modelReset();
    occ = 0;
    pend.delete();
    expMode = 3'b110; expWord = 4'h0; expCmd = 1'b0; expBusy = 1'b0;
    expErrPulse = 1'b0; expErrCode = 2'b00; expErrFlag = 1'b0; expDepth = 4'd0;
  endtask

  task automatic modelIssue(input logic [2:0] m, input logic [3:0] w);
    int need;
    int delta;
    need = 0;
    delta = 0;
    case (m)
      3'b001:         begin need = 0; delta = 1;  end
      3'b000:         begin need = 1; delta = -1; end
      3'b010, 3'b011: begin need = 2; delta = -1; end
      3'b100:         begin need = 2; delta = 0;  end
      3'b101:         begin need = 1; delta = 1;  end
      default:        begin need = 0; delta = 0;  end
    endcase
    if (DCHK && occ < need) begin
      expErrPulse = 1'b1; expErrCode = 2'b10; expErrFlag = 1'b1;
    end else if (DCHK && occ + delta > DEPTH) begin
      expErrPulse = 1'b1; expErrCode = 2'b11; expErrFlag = 1'b1;
    end else begin
      expCmd = 1'b1; expMode = m; expWord = w;
      occ = occ + delta;
    end
  endtask

  task automatic modelStep(input logic v, input logic [3:0] n);
    expCmd = 1'b0; expMode = 3'b110; expWord = 4'h0; expErrPulse = 1'b0;
    if (v) begin
      if (pend.size() == 0) begin
        case (n)
          4'h0: begin end
          4'h1, 4'h7: pend.push_back(n);
          4'h2: modelIssue(3'b000, 4'h0);
          4'h3: modelIssue(3'b010, 4'h0);
          4'h4: modelIssue(3'b011, 4'h0);
          4'h5: modelIssue(3'b100, 4'h0);
          4'h6: modelIssue(3'b101, 4'h0);
          default: begin
            expErrPulse = 1'b1; expErrCode = 2'b01; expErrFlag = 1'b1;
          end
        endcase
      end else begin
        modelIssue(3'b001, n);
        pend.push_back(n);
        if (pend[0] == 4'h1 || pend.size() == 3) pend.delete();
      end
    end
    expBusy = (pend.size() != 0);
    expDepth = DCHK ? 4'(occ) : 4'd0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".mode"},      32'(busIf.mode),      32'(expMode));
    chk({tag, ".in_word"},   32'(busIf.in_word),   32'(expWord));
    chk({tag, ".cmd_valid"}, 32'(busIf.cmd_valid), 32'(expCmd));
    chk({tag, ".busy"},      32'(busIf.busy),      32'(expBusy));
    chk({tag, ".depth"},     32'(busIf.depth),     32'(expDepth));
    chk({tag, ".err_pulse"}, 32'(busIf.err_pulse), 32'(expErrPulse));
    chk({tag, ".err_code"},  32'(busIf.err_code),  32'(expErrCode));
    chk({tag, ".err_flag"},  32'(busIf.err_flag),  32'(expErrFlag));
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] n);
    @(negedge clk);
    busIf.in_valid = v;
    busIf.in_nibble = n;
    @(posedge clk);
    #1;
    modelStep(v, n);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    busIf.in_valid = 1'b0;
    busIf.in_nibble = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("reset");
  endtask

  vec_t vecs[13];

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    checks = 0;
    errors = 0;
    busIf.in_valid = 1'b0;
    busIf.in_nibble = 4'h0;
    modelReset();

    // Directed table: push with operand, illegal opcode, pop, ADD on empty, PUSH2, DUP/SWAP/SUB.
    vecs[0]  = mk(1'b1, 4'h1, 3'b110, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, dv(0), 1'b1);
    vecs[1]  = mk(1'b1, 4'h5, 3'b001, 4'h5, 1'b1, 1'b0, 2'b00, 1'b0, dv(1), 1'b0);
    vecs[2]  = mk(1'b0, 4'h3, 3'b110, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, dv(1), 1'b0);
    vecs[3]  = mk(1'b1, 4'hC, 3'b110, 4'h0, 1'b0, 1'b1, 2'b01, 1'b1, dv(1), 1'b0);
    vecs[4]  = mk(1'b1, 4'h2, 3'b000, 4'h0, 1'b1, 1'b0, 2'b01, 1'b1, dv(0), 1'b0);
    vecs[5]  = mk(1'b1, 4'h3, DCHK ? 3'b110 : 3'b010, 4'h0, !DCHK, DCHK,
                  DCHK ? 2'b10 : 2'b01, 1'b1, dv(0), 1'b0);
    vecs[6]  = mk(1'b1, 4'h7, 3'b110, 4'h0, 1'b0, 1'b0, DCHK ? 2'b10 : 2'b01, 1'b1, dv(0), 1'b1);
    vecs[7]  = mk(1'b1, 4'h9, 3'b001, 4'h9, 1'b1, 1'b0, DCHK ? 2'b10 : 2'b01, 1'b1, dv(1), 1'b1);
    vecs[8]  = mk(1'b0, 4'h0, 3'b110, 4'h0, 1'b0, 1'b0, DCHK ? 2'b10 : 2'b01, 1'b1, dv(1), 1'b1);
    vecs[9]  = mk(1'b1, 4'h4, 3'b001, 4'h4, 1'b1, 1'b0, DCHK ? 2'b10 : 2'b01, 1'b1, dv(2), 1'b0);
    vecs[10] = mk(1'b1, 4'h6, 3'b101, 4'h0, 1'b1, 1'b0, DCHK ? 2'b10 : 2'b01, 1'b1, dv(3), 1'b0);
    vecs[11] = mk(1'b1, 4'h5, 3'b100, 4'h0, 1'b1, 1'b0, DCHK ? 2'b10 : 2'b01, 1'b1, dv(3), 1'b0);
    vecs[12] = mk(1'b1, 4'h4, 3'b011, 4'h0, 1'b1, 1'b0, DCHK ? 2'b10 : 2'b01, 1'b1, dv(2), 1'b0);

    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].v, vecs[i].n);
      chk($sformatf("vec%0d.mode", i),      32'(busIf.mode),      32'(vecs[i].mode));
      chk($sformatf("vec%0d.in_word", i),   32'(busIf.in_word),   32'(vecs[i].word));
      chk($sformatf("vec%0d.cmd_valid", i), 32'(busIf.cmd_valid), 32'(vecs[i].cmd));
      chk($sformatf("vec%0d.err_pulse", i), 32'(busIf.err_pulse), 32'(vecs[i].errP));
      chk($sformatf("vec%0d.err_code", i),  32'(busIf.err_code),  32'(vecs[i].code));
      chk($sformatf("vec%0d.err_flag", i),  32'(busIf.err_flag),  32'(vecs[i].flag));
      chk($sformatf("vec%0d.depth", i),     32'(busIf.depth),     32'(vecs[i].depth));
      chk($sformatf("vec%0d.busy", i),      32'(busIf.busy),      32'(vecs[i].busy));
    end

    // Fill the stack with four PUSH2 runs, then push once more into a full stack.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'h7);        checkOutput("fill.op");
      applyStimulus(1'b1, 4'(2 * i));   checkOutput("fill.a");
      applyStimulus(1'b1, 4'(2 * i + 1)); checkOutput("fill.b");
    end
    chk("fill.depth", 32'(busIf.depth), 32'(dv(8)));
    applyStimulus(1'b1, 4'h1); checkOutput("ovf.op");
    applyStimulus(1'b1, 4'hA); checkOutput("ovf.opnd");
    chk("ovf.cmd_valid", 32'(busIf.cmd_valid), 32'(!DCHK));
    chk("ovf.err_code",  32'(busIf.err_code),  DCHK ? 32'd3 : 32'd0);
    chk("ovf.depth",     32'(busIf.depth),     32'(dv(8)));
    // PUSH2 and DUP against a full stack, then drain past empty.
    applyStimulus(1'b1, 4'h7); checkOutput("ovf2.op");
    applyStimulus(1'b1, 4'h3); checkOutput("ovf2.a");
    chk("ovf2.busy", 32'(busIf.busy), 32'd1);
    applyStimulus(1'b1, 4'hE); checkOutput("ovf2.b");
    applyStimulus(1'b1, 4'h6); checkOutput("ovf.dup");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 4'h2); checkOutput("drain");
    end
    applyStimulus(1'b1, 4'h6); checkOutput("udf.dup");

    // Reset lands mid-operand while the operand nibble is being presented.
    doReset();
    applyStimulus(1'b1, 4'h1); checkOutput("midrst.op");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'h0); checkOutput("midrst.hold");
    end
    @(negedge clk);
    busIf.in_valid = 1'b1;
    busIf.in_nibble = 4'hA;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    checkOutput("midrst.inreset");
    @(negedge clk);
    busIf.in_valid = 1'b0;
    rst = 1'b1;
    applyStimulus(1'b0, 4'h0); checkOutput("midrst.after");
    applyStimulus(1'b1, 4'h2); checkOutput("midrst.pop");

    // Randomized nibble streams checked against the model every cycle.
    for (int run = 0; run < 3; run++) begin
      doReset();
      for (int i = 0; i < 300; i++) begin
        logic       v;
        logic [3:0] n;
        int unsigned r;
        v = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        if (r < 3) n = (r == 0) ? 4'h7 : 4'h1;
        else if (r < 5) n = 4'($urandom_range(2, 6));
        else n = 4'($urandom_range(0, 15));
        applyStimulus(v, n);
        checkOutput($sformatf("rand%0d.%0d", run, i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
